decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: WB_BYPASS, default 1, forwards a same-cycle writeback to register reads when 1.
REQ-002 Port: clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: pipe_flush  in  1  squashes the instruction currently held in IF/ID.
REQ-005 Port: if_id__pc  in  32  PC of the IF/ID instruction.
REQ-006 Port: if_id__ins  in  32  IF/ID instruction word.
REQ-007 Port: if_id__ins_misalign  in  1  fetch PC was not word aligned.
REQ-008 Port: if_id__predict_taken  in  1  fetch predicted this instruction taken.
REQ-009 Port: wb_id__rd_write, wb_id__rd_index, wb_id__rd_data  in  1/5/32  register-file write port.
REQ-010 Port: data_hazard  out  1  combinational stall request to fetch.
REQ-011 Port: id_ex__valid, id_ex__pc, id_ex__rs1_data, id_ex__rs2_data, id_ex__imm  out  1/32/32/32/32  ID/EX payload.
REQ-012 Port: id_ex__rs1_index, id_ex__rs2_index, id_ex__rd_index, id_ex__rd_write  out  5/5/5/1  register fields.
REQ-013 Port: id_ex__alu_op  out  4  ALU op; id_ex__mem_read, id_ex__mem_write, id_ex__branch, id_ex__jump, id_ex__predict_taken  out  1 each.
REQ-014 Port: id_ex__illegal, id_ex__ins_misalign  out  1/1  trap causes carried to EX.

Function
REQ-015 Decode of RV32I base opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP), SYSTEM (treated as illegal).
REQ-016 Immediate generation per I/S/B/U/J format, sign-extended to 32 bits; bit 0 of B and J immediates is 0.
REQ-017 Unknown opcode, or unknown funct3/funct7 within OP/OP-IMM -> illegal=1, rd_write=0, mem_read=0, mem_write=0.
REQ-018 rd_write is forced to 0 when rd_index==0.
REQ-019 Latency is one cycle: IF/ID inputs sampled at edge N appear on id_ex__* after edge N.
REQ-020 Load-use hazard: data_hazard=1 when id_ex__valid & id_ex__mem_read & id_ex__rd_index!=0 & (rd_index==rs1 used, or ==rs2 used).
REQ-021 Only source fields the opcode actually reads count as "used" for REQ-020: LUI, AUIPC and JAL use none; I-type uses rs1 only.
REQ-022 While data_hazard=1 the next ID/EX entry is a bubble: valid=0, all control bits 0, payload don't-care.
REQ-023 pipe_flush=1 -> the next ID/EX entry is a bubble and data_hazard=0; flush has priority over hazard.
REQ-024 Register file: 32x32, two asynchronous read ports, one write port written on the clock edge; x0 always reads 0 and writes to it are ignored.
REQ-025 WB_BYPASS=1: a read whose index equals wb_id__rd_index!=0 with wb_id__rd_write=1 returns wb_id__rd_data in the same cycle.
REQ-026 if_id__ins_misalign=1 -> id_ex__ins_misalign=1 and all control bits 0 except valid.
REQ-027 id_ex__predict_taken is copied from if_id__predict_taken for valid entries, 0 for bubbles.

Reset
REQ-028 rst_n low -> every id_ex__* output is 0 immediately (asynchronously), including valid.
REQ-029 The register file is not reset; its contents are undefined until written.
REQ-030 rst_n deassertion mid-stream -> first post-reset edge captures the IF/ID inputs normally.

Structure
REQ-031 A shared package holds the opcode constants, the ALU op encodings (4-bit) and the immediate-format enum.
REQ-032 The register file is the single sub-module, named regfile.

Verification
REQ-033 ADDI x1,x0,5 (0x00500093), pc=0x40 -> next cycle valid=1, rd_index=1, rd_write=1, imm=5, pc=0x40.
REQ-034 LW x2,0(x1), then ADD x3,x2,x2 -> data_hazard=1 for one cycle, one bubble inserted, ADD issues the following cycle.
REQ-035 pipe_flush=1 with a LW in ID/EX and a dependent ADD in IF/ID -> data_hazard=0, next id_ex__valid=0.
REQ-036 WB writes x5=0xDEADBEEF in the same cycle ADD x6,x5,x0 decodes -> rs1_data=0xDEADBEEF; write to x0 -> read back 0.
REQ-037 Instruction 0xFFFFFFFF -> illegal=1, rd_write=0; BEQ imm -4096 -> id_ex__imm=0xFFFFF000.
REQ-038 rst_n pulsed low asynchronously mid-stream -> all id_ex__* outputs 0 before the next edge.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode, ALU op and immediate-format definitions for decode
//
// Purpose: constants and types shared by the decode stage and its register file.
//   - RV32I major opcodes
//   - 4-bit ALU operation encodings
//   - immediate format enum and the immediate generator
//   - packed ID/EX pipeline register layout
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic [4:0]  rd_index;
    logic        rd_write;
    alu_op_e     alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        predict_taken;
    logic        illegal;
    logic        ins_misalign;
  } id_ex_t;

  // Sign-extended immediate; B and J formats have an implicit zero LSB.
  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // funct3 to ALU op; alt selects SUB/SRA on the two funct3 codes that have one.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 32x32 register file, two async read ports, one clocked write port
//
// Purpose: architectural integer registers for the decode stage.
// Ports:
//   clk                    write clock
//   rs1_index / rs1_data   read port 1 (combinational)
//   rs2_index / rs2_data   read port 2 (combinational)
//   wr_en, wr_index, wr_data  write port, committed on the rising edge
// x0 reads as zero and ignores writes. Contents are not reset.
module regfile #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_index,
  input  logic [31:0] wr_data
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_index != 5'd0)) begin
      mem[wr_index] <= wr_data;
    end
  end

  // A write landing this cycle is forwarded so the reader sees it without
  // waiting for the array update.
  function automatic logic [31:0] read_port(input logic [4:0] index, input logic [31:0] stored);
    logic [31:0] value;
    if (index == 5'd0) begin
      value = 32'd0;
    end else if (WB_BYPASS && wr_en && (wr_index == index)) begin
      value = wr_data;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  assign rs1_data = read_port(rs1_index, mem[rs1_index]);
  assign rs2_data = read_port(rs2_index, mem[rs2_index]);

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - RV32I instruction decode stage with load-use hazard detection
//
// Purpose: decodes the IF/ID instruction, reads the register file and registers
// the result into the ID/EX pipeline register one cycle later.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   pipe_flush                     squash the IF/ID instruction
//   if_id__*                       fetched instruction, PC, misalign flag, prediction
//   wb_id__*                       register-file write port from writeback
//   data_hazard                    combinational stall request to fetch
//   id_ex__*                       registered ID/EX payload and control
module decode
  import decode_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic [31:0] if_id__pc,
  input  logic [31:0] if_id__ins,
  input  logic        if_id__ins_misalign,
  input  logic        if_id__predict_taken,
  input  logic        wb_id__rd_write,
  input  logic [4:0]  wb_id__rd_index,
  input  logic [31:0] wb_id__rd_data,
  output logic        data_hazard,
  output logic        id_ex__valid,
  output logic [31:0] id_ex__pc,
  output logic [31:0] id_ex__rs1_data,
  output logic [31:0] id_ex__rs2_data,
  output logic [31:0] id_ex__imm,
  output logic [4:0]  id_ex__rs1_index,
  output logic [4:0]  id_ex__rs2_index,
  output logic [4:0]  id_ex__rd_index,
  output logic        id_ex__rd_write,
  output logic [3:0]  id_ex__alu_op,
  output logic        id_ex__mem_read,
  output logic        id_ex__mem_write,
  output logic        id_ex__branch,
  output logic        id_ex__jump,
  output logic        id_ex__predict_taken,
  output logic        id_ex__illegal,
  output logic        id_ex__ins_misalign
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = if_id__ins[6:0];
  assign rd     = if_id__ins[11:7];
  assign funct3 = if_id__ins[14:12];
  assign rs1    = if_id__ins[19:15];
  assign rs2    = if_id__ins[24:20];
  assign funct7 = if_id__ins[31:25];

  logic [31:0] rs1_data, rs2_data;

  regfile #(.WB_BYPASS(WB_BYPASS)) u_regfile (
    .clk       (clk),
    .rs1_index (rs1),
    .rs2_index (rs2),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wr_en     (wb_id__rd_write),
    .wr_index  (wb_id__rd_index),
    .wr_data   (wb_id__rd_data)
  );

  logic     dec_illegal, dec_rd_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic     use_rs1, use_rs2;
  alu_op_e  dec_alu_op;
  imm_fmt_e dec_fmt;

  always_comb begin
    dec_illegal   = 1'b0;
    dec_rd_write  = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_fmt       = IMM_NONE;
    case (opcode)
      OPC_LUI: begin
        dec_rd_write = 1'b1;
        dec_fmt      = IMM_U;
        dec_alu_op   = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_rd_write = 1'b1;
        dec_fmt      = IMM_U;
      end
      OPC_JAL: begin
        dec_rd_write = 1'b1;
        dec_jump     = 1'b1;
        dec_fmt      = IMM_J;
      end
      OPC_JALR: begin
        dec_rd_write = 1'b1;
        dec_jump     = 1'b1;
        dec_fmt      = IMM_I;
        use_rs1      = 1'b1;
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        dec_fmt    = IMM_B;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_LOAD: begin
        dec_rd_write = 1'b1;
        dec_mem_read = 1'b1;
        dec_fmt      = IMM_I;
        use_rs1      = 1'b1;
      end
      OPC_STORE: begin
        dec_mem_write = 1'b1;
        dec_fmt       = IMM_S;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_rd_write = 1'b1;
        dec_fmt      = IMM_I;
        use_rs1      = 1'b1;
        // Only the shift-immediates constrain funct7; SRAI is the one alt form.
        dec_alu_op   = alu_from_funct(funct3, (funct3 == 3'b101) && (funct7 == FUNCT7_ALT));
        if (funct3 == 3'b001) begin
          dec_illegal = (funct7 != FUNCT7_ZERO);
        end else if (funct3 == 3'b101) begin
          dec_illegal = (funct7 != FUNCT7_ZERO) && (funct7 != FUNCT7_ALT);
        end
      end
      OPC_OP: begin
        dec_rd_write = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec_alu_op   = alu_from_funct(funct3, funct7 == FUNCT7_ALT);
        dec_illegal  = !((funct7 == FUNCT7_ZERO) ||
                         ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM: ;  // FENCE behaves as a NOP in this in-order pipe
      default: dec_illegal = 1'b1;  // includes SYSTEM
    endcase
  end

  id_ex_t id_ex_q, id_ex_d;

  // Stall only on a load whose destination is actually read by this instruction.
  assign data_hazard = !pipe_flush && id_ex_q.valid && id_ex_q.mem_read &&
                       (id_ex_q.rd_index != 5'd0) &&
                       ((use_rs1 && (rs1 == id_ex_q.rd_index)) ||
                        (use_rs2 && (rs2 == id_ex_q.rd_index)));

  always_comb begin
    id_ex_d               = '0;
    id_ex_d.pc            = if_id__pc;
    id_ex_d.rs1_data      = rs1_data;
    id_ex_d.rs2_data      = rs2_data;
    id_ex_d.imm           = gen_imm(if_id__ins, dec_fmt);
    id_ex_d.rs1_index     = rs1;
    id_ex_d.rs2_index     = rs2;
    id_ex_d.rd_index      = rd;
    id_ex_d.alu_op        = dec_alu_op;
    if (!(pipe_flush || data_hazard)) begin
      id_ex_d.valid         = 1'b1;
      id_ex_d.predict_taken = if_id__predict_taken;
      if (if_id__ins_misalign) begin
        // Fetch trap wins: the word is not a real instruction.
        id_ex_d.ins_misalign = 1'b1;
      end else begin
        id_ex_d.illegal   = dec_illegal;
        id_ex_d.rd_write  = dec_rd_write && !dec_illegal && (rd != 5'd0);
        id_ex_d.mem_read  = dec_mem_read && !dec_illegal;
        id_ex_d.mem_write = dec_mem_write && !dec_illegal;
        id_ex_d.branch    = dec_branch && !dec_illegal;
        id_ex_d.jump      = dec_jump && !dec_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign id_ex__valid         = id_ex_q.valid;
  assign id_ex__pc            = id_ex_q.pc;
  assign id_ex__rs1_data      = id_ex_q.rs1_data;
  assign id_ex__rs2_data      = id_ex_q.rs2_data;
  assign id_ex__imm           = id_ex_q.imm;
  assign id_ex__rs1_index     = id_ex_q.rs1_index;
  assign id_ex__rs2_index     = id_ex_q.rs2_index;
  assign id_ex__rd_index      = id_ex_q.rd_index;
  assign id_ex__rd_write      = id_ex_q.rd_write;
  assign id_ex__alu_op        = id_ex_q.alu_op;
  assign id_ex__mem_read      = id_ex_q.mem_read;
  assign id_ex__mem_write     = id_ex_q.mem_write;
  assign id_ex__branch        = id_ex_q.branch;
  assign id_ex__jump          = id_ex_q.jump;
  assign id_ex__predict_taken = id_ex_q.predict_taken;
  assign id_ex__illegal       = id_ex_q.illegal;
  assign id_ex__ins_misalign  = id_ex_q.ins_misalign;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed self-checking bench for the decode stage
module tb_decode;

  logic        clk;
  logic        rst_n;
  logic        pipe_flush;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;
  logic        if_id__ins_misalign;
  logic        if_id__predict_taken;
  logic        wb_id__rd_write;
  logic [4:0]  wb_id__rd_index;
  logic [31:0] wb_id__rd_data;
  logic        data_hazard;
  logic        id_ex__valid;
  logic [31:0] id_ex__pc;
  logic [31:0] id_ex__rs1_data;
  logic [31:0] id_ex__rs2_data;
  logic [31:0] id_ex__imm;
  logic [4:0]  id_ex__rs1_index;
  logic [4:0]  id_ex__rs2_index;
  logic [4:0]  id_ex__rd_index;
  logic        id_ex__rd_write;
  logic [3:0]  id_ex__alu_op;
  logic        id_ex__mem_read;
  logic        id_ex__mem_write;
  logic        id_ex__branch;
  logic        id_ex__jump;
  logic        id_ex__predict_taken;
  logic        id_ex__illegal;
  logic        id_ex__ins_misalign;

  int checks = 0;
  int errors = 0;

  decode #(.WB_BYPASS(1'b1)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pipe_flush           (pipe_flush),
    .if_id__pc            (if_id__pc),
    .if_id__ins           (if_id__ins),
    .if_id__ins_misalign  (if_id__ins_misalign),
    .if_id__predict_taken (if_id__predict_taken),
    .wb_id__rd_write      (wb_id__rd_write),
    .wb_id__rd_index      (wb_id__rd_index),
    .wb_id__rd_data       (wb_id__rd_data),
    .data_hazard          (data_hazard),
    .id_ex__valid         (id_ex__valid),
    .id_ex__pc            (id_ex__pc),
    .id_ex__rs1_data      (id_ex__rs1_data),
    .id_ex__rs2_data      (id_ex__rs2_data),
    .id_ex__imm           (id_ex__imm),
    .id_ex__rs1_index     (id_ex__rs1_index),
    .id_ex__rs2_index     (id_ex__rs2_index),
    .id_ex__rd_index      (id_ex__rd_index),
    .id_ex__rd_write      (id_ex__rd_write),
    .id_ex__alu_op        (id_ex__alu_op),
    .id_ex__mem_read      (id_ex__mem_read),
    .id_ex__mem_write     (id_ex__mem_write),
    .id_ex__branch        (id_ex__branch),
    .id_ex__jump          (id_ex__jump),
    .id_ex__predict_taken (id_ex__predict_taken),
    .id_ex__illegal       (id_ex__illegal),
    .id_ex__ins_misalign  (id_ex__ins_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n                = 1'b0;
    pipe_flush           = 1'b0;
    if_id__pc            = 32'h40;
    if_id__ins           = 32'h00500093;  // ADDI x1,x0,5
    if_id__ins_misalign  = 1'b0;
    if_id__predict_taken = 1'b0;
    wb_id__rd_write      = 1'b0;
    wb_id__rd_index      = 5'd0;
    wb_id__rd_data       = 32'd0;
    #1;
    chk("reset_valid", 32'(id_ex__valid), 32'd0);
    chk("reset_pc", id_ex__pc, 32'd0);
    chk("reset_rd_write", 32'(id_ex__rd_write), 32'd0);
    #1 rst_n = 1'b1;

    // ADDI x1,x0,5 at pc 0x40
    tick();
    chk("addi_valid", 32'(id_ex__valid), 32'd1);
    chk("addi_rd", 32'(id_ex__rd_index), 32'd1);
    chk("addi_rd_write", 32'(id_ex__rd_write), 32'd1);
    chk("addi_imm", id_ex__imm, 32'd5);
    chk("addi_pc", id_ex__pc, 32'h40);
    chk("addi_alu", 32'(id_ex__alu_op), 32'd0);
    chk("addi_illegal", 32'(id_ex__illegal), 32'd0);

    // LW x2,0(x1) then dependent ADD x3,x2,x2
    if_id__pc = 32'h44; if_id__ins = 32'h0000A103;
    tick();
    chk("lw_mem_read", 32'(id_ex__mem_read), 32'd1);
    chk("lw_rd", 32'(id_ex__rd_index), 32'd2);
    if_id__pc = 32'h48; if_id__ins = 32'h002101B3;
    #1;
    chk("lu_hazard", 32'(data_hazard), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(id_ex__valid), 32'd0);
    chk("lu_bubble_rd_write", 32'(id_ex__rd_write), 32'd0);
    chk("lu_bubble_mem_read", 32'(id_ex__mem_read), 32'd0);
    chk("lu_hazard_clear", 32'(data_hazard), 32'd0);
    tick();
    chk("add_valid", 32'(id_ex__valid), 32'd1);
    chk("add_rd", 32'(id_ex__rd_index), 32'd3);
    chk("add_rs1", 32'(id_ex__rs1_index), 32'd2);
    chk("add_rs2", 32'(id_ex__rs2_index), 32'd2);
    chk("add_pc", id_ex__pc, 32'h48);

    // Flush beats hazard
    if_id__pc = 32'h4C; if_id__ins = 32'h0000A103;
    tick();
    if_id__pc = 32'h50; if_id__ins = 32'h002101B3; pipe_flush = 1'b1;
    #1;
    chk("flush_hazard", 32'(data_hazard), 32'd0);
    tick();
    chk("flush_valid", 32'(id_ex__valid), 32'd0);
    pipe_flush = 1'b0;

    // Same-cycle writeback bypass: x5 = DEADBEEF, ADD x6,x5,x0
    wb_id__rd_write = 1'b1; wb_id__rd_index = 5'd5; wb_id__rd_data = 32'hDEADBEEF;
    if_id__pc = 32'h54; if_id__ins = 32'h00028333;
    tick();
    chk("bypass_rs1", id_ex__rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2_x0", id_ex__rs2_data, 32'd0);
    wb_id__rd_write = 1'b0;
    if_id__pc = 32'h58; if_id__ins = 32'h000283B3;  // ADD x7,x5,x0
    tick();
    chk("stored_rs1", id_ex__rs1_data, 32'hDEADBEEF);

    // Write to x0 is ignored
    wb_id__rd_write = 1'b1; wb_id__rd_index = 5'd0; wb_id__rd_data = 32'h12345678;
    if_id__pc = 32'h5C; if_id__ins = 32'h00000433;  // ADD x8,x0,x0
    tick();
    chk("x0_bypass", id_ex__rs1_data, 32'd0);
    wb_id__rd_write = 1'b0;
    tick();
    chk("x0_stored", id_ex__rs1_data, 32'd0);

    // Unused source fields must not stall: I-type rs2 field, LUI fields
    if_id__ins = 32'h0000A403;  // LW x8,0(x1)
    tick();
    if_id__ins = 32'h00808493;  // ADDI x9,x1,8 (rs2 field = 8)
    #1;
    chk("itype_no_hazard", 32'(data_hazard), 32'd0);
    tick();
    chk("itype_valid", 32'(id_ex__valid), 32'd1);
    chk("itype_imm", id_ex__imm, 32'd8);
    if_id__ins = 32'h0000A403;
    tick();
    if_id__ins = 32'h123452B7;  // LUI x5,0x12345 (rs1 field = 8)
    #1;
    chk("lui_no_hazard", 32'(data_hazard), 32'd0);
    tick();
    chk("lui_imm", id_ex__imm, 32'h12345000);
    chk("lui_rd", 32'(id_ex__rd_index), 32'd5);

    // S and J immediates
    if_id__ins = 32'hFE20AE23;  // SW x2,-4(x1)
    tick();
    chk("sw_imm", id_ex__imm, 32'hFFFFFFFC);
    chk("sw_mem_write", 32'(id_ex__mem_write), 32'd1);
    chk("sw_rd_write", 32'(id_ex__rd_write), 32'd0);
    if_id__ins = 32'h008000EF;  // JAL x1,+8
    tick();
    chk("jal_imm", id_ex__imm, 32'd8);
    chk("jal_jump", 32'(id_ex__jump), 32'd1);

    // Illegal and BEQ -4096 with prediction
    if_id__ins = 32'hFFFFFFFF;
    tick();
    chk("ill_illegal", 32'(id_ex__illegal), 32'd1);
    chk("ill_rd_write", 32'(id_ex__rd_write), 32'd0);
    if_id__ins = 32'h80000063; if_id__predict_taken = 1'b1;
    tick();
    chk("beq_imm", id_ex__imm, 32'hFFFFF000);
    chk("beq_branch", 32'(id_ex__branch), 32'd1);
    chk("beq_predict", 32'(id_ex__predict_taken), 32'd1);
    if_id__predict_taken = 1'b0;

    // Misaligned fetch
    if_id__ins = 32'h00500093; if_id__ins_misalign = 1'b1;
    tick();
    chk("mis_valid", 32'(id_ex__valid), 32'd1);
    chk("mis_flag", 32'(id_ex__ins_misalign), 32'd1);
    chk("mis_rd_write", 32'(id_ex__rd_write), 32'd0);
    if_id__ins_misalign = 1'b0;

    // Asynchronous reset mid-stream
    if_id__pc = 32'h80;
    tick();
    chk("pre_rst_valid", 32'(id_ex__valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(id_ex__valid), 32'd0);
    chk("arst_pc", id_ex__pc, 32'd0);
    chk("arst_imm", id_ex__imm, 32'd0);
    chk("arst_rd_write", 32'(id_ex__rd_write), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(id_ex__valid), 32'd1);
    chk("post_rst_pc", id_ex__pc, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
